// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

    localparam int BLOCK_W     = 128;
    localparam int OFFSET_W    = 2;
    localparam int DEF_INDEX_W = 3;
    localparam int DEF_TAG_W   = 3;

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        UPDATE
    } state_t;

endpackage

// File: rtl/icache_ctrl.sv
// Miss-handling FSM for the instruction cache: latches the missing block address,
// runs the memory read and signals when the fill may be written.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     hit,
    input  logic [TAG_W-1:0]         pc_tag,
    input  logic [INDEX_W-1:0]       pc_index,
    input  logic                     mem_busywait,
    output logic                     busywait,
    output logic                     mem_read,
    output logic [TAG_W+INDEX_W-1:0] mem_address,
    output logic                     capture,
    output logic                     fill_en,
    output logic [TAG_W-1:0]         fill_tag,
    output logic [INDEX_W-1:0]       fill_index
);

    state_t               state;
    state_t               next_state;
    logic [TAG_W-1:0]     miss_tag;
    logic [INDEX_W-1:0]   miss_index;

    // The miss address is frozen when leaving IDLE so later PC changes cannot redirect the fill.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            miss_tag   <= '0;
            miss_index <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && !hit) begin
                miss_tag   <= pc_tag;
                miss_index <= pc_index;
            end
        end
    end

    always_comb begin
        next_state  = state;
        busywait    = 1'b1;
        mem_read    = 1'b0;
        mem_address = '0;
        capture     = 1'b0;
        fill_en     = 1'b0;
        case (state)
            IDLE: begin
                busywait = !hit;
                if (!hit) next_state = MEM_READ;
            end
            MEM_READ: begin
                mem_read    = 1'b1;
                mem_address = {miss_tag, miss_index};
                if (!mem_busywait) begin
                    capture    = 1'b1;
                    next_state = UPDATE;
                end
            end
            UPDATE: begin
                fill_en    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign fill_tag   = miss_tag;
    assign fill_index = miss_index;

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with 4-word blocks and zero-cycle hits.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [31:0]              PC,
    output logic [31:0]              INSTRUCTION,
    output logic                     BUSYWAIT,
    output logic                     MEM_READ,
    output logic [TAG_W+INDEX_W-1:0] MEM_ADDRESS,
    input  logic [BLOCK_W-1:0]       MEM_READDATA,
    input  logic                     MEM_BUSYWAIT
);

    localparam int NUM_BLOCKS = 2 ** INDEX_W;
    localparam int ADDR_W     = TAG_W + INDEX_W + 4;

    logic [OFFSET_W-1:0]   pc_offset;
    logic [INDEX_W-1:0]    pc_index;
    logic [TAG_W-1:0]      pc_tag;
    logic                  unused_pc_bits;

    logic [NUM_BLOCKS-1:0] valid_bits;
    logic [TAG_W-1:0]      tags [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data [NUM_BLOCKS];

    logic                  hit;
    logic [BLOCK_W-1:0]    sel_block;
    logic [31:0]           sel_word;
    logic [BLOCK_W-1:0]    fill_data;
    logic                  capture;
    logic                  fill_en;
    logic [TAG_W-1:0]      fill_tag;
    logic [INDEX_W-1:0]    fill_index;

    assign pc_offset      = PC[3:2];
    assign pc_index       = PC[INDEX_W+3:4];
    assign pc_tag         = PC[ADDR_W-1:INDEX_W+4];
    assign unused_pc_bits = ^{PC[31:ADDR_W], PC[1:0]};

    assign hit         = valid_bits[pc_index] && (tags[pc_index] == pc_tag);
    assign sel_block   = data[pc_index];
    assign sel_word    = sel_block[{pc_offset, 5'b00000} +: 32];
    assign INSTRUCTION = hit ? sel_word : '0;

    icache_ctrl #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_ctrl (
        .CLK          (CLK),
        .RESET        (RESET),
        .hit          (hit),
        .pc_tag       (pc_tag),
        .pc_index     (pc_index),
        .mem_busywait (MEM_BUSYWAIT),
        .busywait     (BUSYWAIT),
        .mem_read     (MEM_READ),
        .mem_address  (MEM_ADDRESS),
        .capture      (capture),
        .fill_en      (fill_en),
        .fill_tag     (fill_tag),
        .fill_index   (fill_index)
    );

    // Only the valid bits need resetting; tag and data are ignored while invalid.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_bits <= '0;
        end else if (fill_en) begin
            valid_bits[fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (capture) begin
            fill_data <= MEM_READDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tags[fill_index] <= fill_tag;
            data[fill_index] <= fill_data;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: behavioural block memory with adjustable latency,
// a table of hit vectors and hand-written miss, redirect and reset sequences.
module tb_icache;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [31:0]  PC = '0;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    int checks = 0;
    int failures = 0;
    int mem_latency = 5;
    int mem_cnt = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs [9];

    icache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] exp_word(input logic [5:0] blk, input logic [1:0] k);
        return {16'hC0DE, 2'b00, blk, 6'b000000, k};
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        return exp_word(pc[9:4], pc[3:2]);
    endfunction

    // Memory answers in the mem_latency-th cycle that MEM_READ is held high.
    always @(posedge CLK) begin
        if (MEM_READ) mem_cnt <= mem_cnt + 1;
        else          mem_cnt <= 0;
    end

    assign MEM_BUSYWAIT = ~(MEM_READ & (mem_cnt >= mem_latency - 1));

    always_comb begin
        MEM_READDATA = '0;
        for (int k = 0; k < 4; k++) begin
            MEM_READDATA[32*k +: 32] = exp_word(MEM_ADDRESS, 2'(k));
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] pc);
        @(negedge CLK);
        PC = pc;
        #1;
    endtask

    task automatic do_miss(input logic [31:0] pc, input int lat, input string name);
        mem_latency = lat;
        apply_stimulus(pc);
        check_output({name, " miss busy"}, 32'(BUSYWAIT), 32'd1);
        check_output({name, " miss memread"}, 32'(MEM_READ), 32'd0);
        for (int i = 0; i < lat; i++) begin
            @(negedge CLK); #1;
            check_output({name, " read memread"}, 32'(MEM_READ), 32'd1);
            check_output({name, " read addr"}, 32'(MEM_ADDRESS), 32'(pc[9:4]));
            check_output({name, " read busy"}, 32'(BUSYWAIT), 32'd1);
        end
        @(negedge CLK); #1;
        check_output({name, " update memread"}, 32'(MEM_READ), 32'd0);
        check_output({name, " update addr"}, 32'(MEM_ADDRESS), 32'd0);
        check_output({name, " update busy"}, 32'(BUSYWAIT), 32'd1);
        @(negedge CLK); #1;
        check_output({name, " done busy"}, 32'(BUSYWAIT), 32'd0);
        check_output({name, " done instr"}, INSTRUCTION, exp_instr(pc));
    endtask

    task automatic check_hit(input logic [31:0] pc, input logic [31:0] instr, input string name);
        apply_stimulus(pc);
        check_output({name, " busy"}, 32'(BUSYWAIT), 32'd0);
        check_output({name, " instr"}, INSTRUCTION, instr);
        check_output({name, " memread"}, 32'(MEM_READ), 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h004, 32'hC0DE_0001};
        vecs[1] = '{32'h008, 32'hC0DE_0002};
        vecs[2] = '{32'h00C, 32'hC0DE_0003};
        vecs[3] = '{32'h000, 32'hC0DE_0000};
        vecs[4] = '{32'h014, 32'hC0DE_0101};
        vecs[5] = '{32'h028, 32'hC0DE_0202};
        vecs[6] = '{32'h02C, 32'hC0DE_0203};
        vecs[7] = '{32'h0FC, 32'hC0DE_0F03};
        vecs[8] = '{32'h0F4, 32'hC0DE_0F01};

        @(negedge CLK); #1;
        check_output("reset busy", 32'(BUSYWAIT), 32'd1);
        check_output("reset memread", 32'(MEM_READ), 32'd0);
        check_output("reset addr", 32'(MEM_ADDRESS), 32'd0);
        check_output("reset instr", INSTRUCTION, 32'd0);
        @(posedge CLK); #2;
        RESET = 1'b1;

        do_miss(32'h000, 5, "fill0");
        for (int i = 1; i < 4; i++) begin
            check_hit(32'(4 * i), 32'hC0DE_0000 | 32'(i), "first block hit");
        end

        do_miss(32'h080, 3, "conflict");
        check_hit(32'h084, 32'hC0DE_0801, "conflict hit");
        do_miss(32'h000, 2, "refill0");

        // PC moves to 0x020 mid-read; the fill must still land in index 1.
        mem_latency = 5;
        apply_stimulus(32'h010);
        check_output("redirect miss busy", 32'(BUSYWAIT), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (i == 2) PC = 32'h020;
            #1;
            check_output("redirect read memread", 32'(MEM_READ), 32'd1);
            check_output("redirect read addr", 32'(MEM_ADDRESS), 32'h01);
        end
        @(negedge CLK); #1;
        check_output("redirect update memread", 32'(MEM_READ), 32'd0);
        check_output("redirect update busy", 32'(BUSYWAIT), 32'd1);
        @(negedge CLK); #1;
        check_output("redirect new miss busy", 32'(BUSYWAIT), 32'd1);
        check_output("redirect new miss memread", 32'(MEM_READ), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK); #1;
            check_output("redirect second addr", 32'(MEM_ADDRESS), 32'h02);
        end
        @(negedge CLK); #1;
        check_output("redirect second update", 32'(MEM_READ), 32'd0);
        @(negedge CLK); #1;
        check_output("redirect second done busy", 32'(BUSYWAIT), 32'd0);
        check_output("redirect second done instr", INSTRUCTION, 32'hC0DE_0200);
        check_hit(32'h010, 32'hC0DE_0100, "redirect index1 hit");

        do_miss(32'h0F0, 1, "zero latency");

        for (int i = 0; i < 9; i++) begin
            check_hit(vecs[i].pc, vecs[i].instr, $sformatf("vec%0d", i));
        end

        // Reset in the third read cycle must abort the fill and flush every block.
        mem_latency = 5;
        apply_stimulus(32'h050);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); #1;
            check_output("abort read memread", 32'(MEM_READ), 32'd1);
        end
        RESET = 1'b0;
        #1;
        check_output("abort memread", 32'(MEM_READ), 32'd0);
        check_output("abort busy", 32'(BUSYWAIT), 32'd1);
        check_output("abort addr", 32'(MEM_ADDRESS), 32'd0);
        check_output("abort instr", INSTRUCTION, 32'd0);
        @(posedge CLK); #2;
        RESET = 1'b1;
        do_miss(32'h000, 5, "post reset");
        do_miss(32'h0F4, 2, "post reset flushed");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
